// File: rtl/load_store_unit.sv
// Load/store stage between the core and a synchronous-read data memory without byte enables.
// Sub-word stores use read-modify-write. Misaligned or illegal accesses fault without a memory access.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_data_out
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  logic                  legal_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [31:0]           load_c;
  logic [31:0]           merge_c;

  // Legality of the incoming request: funct3 valid for the direction and naturally aligned.
  always_comb begin
    legal_c = 1'b0;
    case (funct3)
      F3_B:  legal_c = 1'b1;
      F3_H:  legal_c = ~addr[0];
      F3_W:  legal_c = (addr[1:0] == 2'b00);
      F3_BU: legal_c = ~we;
      F3_HU: legal_c = ~we & ~addr[0];
      default: legal_c = 1'b0;
    endcase
  end

  // Lane extraction and extension for loads, plus the read-modify-write merge for SB/SH.
  always_comb begin
    byte_c = mem_data_out[7:0];
    case (lane_q)
      2'd0: byte_c = mem_data_out[7:0];
      2'd1: byte_c = mem_data_out[15:8];
      2'd2: byte_c = mem_data_out[23:16];
      2'd3: byte_c = mem_data_out[31:24];
      default: byte_c = mem_data_out[7:0];
    endcase
    half_c = lane_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];

    load_c = mem_data_out;
    case (funct3_q)
      F3_B:  load_c = {{24{byte_c[7]}}, byte_c};
      F3_BU: load_c = {24'h000000, byte_c};
      F3_H:  load_c = {{16{half_c[15]}}, half_c};
      F3_HU: load_c = {16'h0000, half_c};
      default: load_c = mem_data_out;
    endcase

    merge_c = mem_data_out;
    if (funct3_q == F3_B) begin
      case (lane_q)
        2'd0: merge_c[7:0]   = wdata_q[7:0];
        2'd1: merge_c[15:8]  = wdata_q[7:0];
        2'd2: merge_c[23:16] = wdata_q[7:0];
        2'd3: merge_c[31:24] = wdata_q[7:0];
        default: merge_c = mem_data_out;
      endcase
    end else if (lane_q[1]) begin
      merge_c[31:16] = wdata_q;
    end else begin
      merge_c[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          funct3_d = funct3;
          lane_d   = addr[1:0];
          wdata_d  = wdata[15:0];
          we_d     = we;
          if (!legal_c) begin
            done_d  = 1'b1;
            fault_d = 1'b1;
            rdata_d = 32'h0000_0000;
          end else begin
            mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
            if (we && (funct3 == F3_W)) begin
              mem_wdata_d = wdata;
              mem_we_d    = 1'b1;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          mem_wdata_d = merge_c;
          mem_we_d    = 1'b1;
          state_d     = WR;
        end else begin
          rdata_d = load_c;
          done_d  = 1'b1;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      WR: begin
        done_d  = 1'b1;
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign fault            = fault_q;
  assign rdata            = rdata_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_in      = mem_wdata_q;
  assign mem_write_enable = mem_we_q;

endmodule
